tst_dout_chk_prbs31: RTL



---
 rtl/tst_dout_chk_prbs31.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tst_dout_chk_prbs31.sv
// Self-synchronising PRBS31 (x^31+x^28+1) checker for 28-bit words.
// Seeds from two received words, hunts for lock, then free-runs its own prediction.
module tst_dout_chk_prbs31 #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             vld_i,
    input  logic [27:0]      dat_i,
    output logic             lock_o,
    output logic             err_o,
    output logic [4:0]       err_bits_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    localparam int unsigned DW = 28;
    localparam int unsigned BW = 5;
    localparam int unsigned GW = 4;
    localparam int unsigned RW = 8;
    localparam int unsigned SW = CNT_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SEED0, SEED1, HUNT, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    p1, p1_nxt;
    // Only the top three bits of the older word feed the prediction.
    logic [2:0]       p2_hi, p2_hi_nxt;
    logic [GW-1:0]    good_run, good_nxt, good_inc;
    logic [RW-1:0]    bad_run, bad_nxt, bad_inc;
    logic             lock_nxt, err_nxt;
    logic [BW-1:0]    bits_nxt;
    logic [CNT_W-1:0] wcnt_nxt, ecnt_nxt;
    logic [DW-1:0]    exp_w, diff_w;
    logic [BW-1:0]    pop;
    logic [SW-1:0]    esum;

    assign exp_w    = p1 ^ {p1[24:0], p2_hi};
    assign diff_w   = exp_w ^ dat_i;
    assign pop      = BW'($countones(diff_w));
    assign esum     = SW'(err_cnt_o) + SW'(pop);
    assign good_inc = good_run + GW'(1);
    assign bad_inc  = bad_run + RW'(1);

    // Next-state, prediction history and registered output values.
    always_comb begin
        state_nxt = state;
        p1_nxt    = p1;
        p2_hi_nxt = p2_hi;
        good_nxt  = good_run;
        bad_nxt   = bad_run;
        lock_nxt  = lock_o;
        err_nxt   = 1'b0;
        bits_nxt  = err_bits_o;
        wcnt_nxt  = word_cnt_o;
        ecnt_nxt  = err_cnt_o;

        if (vld_i) begin
            case (state)
                SEED0: begin
                    p2_hi_nxt = dat_i[27:25];
                    state_nxt = SEED1;
                end
                SEED1: begin
                    p1_nxt    = dat_i;
                    good_nxt  = '0;
                    state_nxt = HUNT;
                end
                HUNT: begin
                    bits_nxt  = pop;
                    p2_hi_nxt = p1[27:25];
                    p1_nxt    = dat_i;
                    if (pop == '0) begin
                        good_nxt = good_inc;
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state_nxt = LOCKED;
                            bad_nxt   = '0;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    bits_nxt  = pop;
                    err_nxt   = (pop != '0);
                    p2_hi_nxt = p1[27:25];
                    // Free-run on the prediction so isolated bit errors do not propagate.
                    p1_nxt    = exp_w;
                    if (word_cnt_o != CNT_MAX) begin
                        wcnt_nxt = word_cnt_o + CNT_W'(1);
                    end
                    ecnt_nxt = (esum > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(esum);
                    if (pop != '0) begin
                        bad_nxt = bad_inc;
                        if (bad_inc == RW'(UNLOCK_CNT)) begin
                            state_nxt = HUNT;
                            good_nxt  = '0;
                            p1_nxt    = dat_i;
                        end
                    end else begin
                        bad_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = SEED0;
                end
            endcase
        end

        if (clr) begin
            wcnt_nxt = '0;
            ecnt_nxt = '0;
        end

        lock_nxt = (state_nxt == LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEED0;
            p1         <= '0;
            p2_hi      <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            lock_o     <= 1'b0;
            err_o      <= 1'b0;
            err_bits_o <= '0;
            word_cnt_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            state      <= state_nxt;
            p1         <= p1_nxt;
            p2_hi      <= p2_hi_nxt;
            good_run   <= good_nxt;
            bad_run    <= bad_nxt;
            lock_o     <= lock_nxt;
            err_o      <= err_nxt;
            err_bits_o <= bits_nxt;
            word_cnt_o <= wcnt_nxt;
            err_cnt_o  <= ecnt_nxt;
        end
    end

endmodule
